// File: rtl/free_list_pkg.sv
// rtl/free_list_pkg.sv - shared register-file constants and retire record for the free list
package free_list_pkg;

    localparam int AR_SIZE  = 32;
    localparam int ZERO_REG = AR_SIZE - 1;
    localparam int PR_SIZE  = 64;
    localparam int PR_BITS  = 6;
    localparam int ZERO_PRN = PR_SIZE - 1;
    localparam int FL_SIZE  = PR_SIZE - 1;

    typedef struct packed {
        logic               valid;
        logic [PR_BITS-1:0] PRN;
    } fl_retire_t;

endpackage

// File: rtl/free_list_if.sv
// rtl/free_list_if.sv - dispatch/retire/offer bundle between the pipeline and the free list
interface free_list_if #(
    parameter int PR_BITS = free_list_pkg::PR_BITS
);
    logic [1:0]              dispatch_req;
    logic [1:0]              retire_valid;
    logic [1:0][PR_BITS-1:0] retire_PRN;
    logic [1:0][PR_BITS-1:0] free_PRN;
    logic [1:0]              free_valid;
    logic [PR_BITS-1:0]      num_free;
    logic                    stall;

    modport master (
        output dispatch_req, retire_valid, retire_PRN,
        input  free_PRN, free_valid, num_free, stall
    );

    modport slave (
        input  dispatch_req, retire_valid, retire_PRN,
        output free_PRN, free_valid, num_free, stall
    );
endinterface

// File: rtl/free_list_fl_idx_inc.sv
// rtl/free_list_fl_idx_inc.sv - circular index advance by 0..2 for a non-power-of-two depth
module fl_idx_inc #(
    parameter int DEPTH = 63,
    parameter int W     = 6
) (
    input  logic [W-1:0] idx,
    input  logic [1:0]   inc,
    output logic [W-1:0] idx_next
);
    logic [W:0] sum;

    always_comb begin
        sum = {1'b0, idx} + {{(W-1){1'b0}}, inc};
        if (sum >= (W+1)'(DEPTH)) begin
            idx_next = W'(sum - (W+1)'(DEPTH));
        end else begin
            idx_next = sum[W-1:0];
        end
    end
endmodule

// File: rtl/free_list.sv
// rtl/free_list.sv - circular FIFO of free physical register numbers feeding the RAT
module free_list #(
    parameter int PR_SIZE = free_list_pkg::PR_SIZE,
    parameter int PR_BITS = free_list_pkg::PR_BITS,
    parameter int FL_SIZE = PR_SIZE - 1
) (
    input  logic        clock,
    input  logic        reset,
    free_list_if.slave  fl
);
    import free_list_pkg::*;

    localparam logic [PR_BITS-1:0] ZERO = PR_BITS'(PR_SIZE - 1);

    logic [PR_BITS-1:0] entries_q [FL_SIZE];
    logic [PR_BITS-1:0] entries_d [FL_SIZE];
    logic [PR_BITS-1:0] head_q, head_d, tail_q, tail_d, count_q, count_d;

    logic [PR_BITS-1:0] head_p1, tail_p1;
    logic [1:0]         pops, pushes;
    logic [1:0]         valid, grant, push_req;
    logic               push0, push1;
    logic [PR_BITS-1:0] prn0, prn1;
    logic [PR_BITS:0]   room_after0;
    logic [PR_BITS+1:0] push_demand;
    fl_retire_t [1:0]   ret;

    fl_idx_inc #(.DEPTH(FL_SIZE), .W(PR_BITS)) u_head_p1  (.idx(head_q), .inc(2'd1), .idx_next(head_p1));
    fl_idx_inc #(.DEPTH(FL_SIZE), .W(PR_BITS)) u_head_adv (.idx(head_q), .inc(pops), .idx_next(head_d));
    fl_idx_inc #(.DEPTH(FL_SIZE), .W(PR_BITS)) u_tail_p1  (.idx(tail_q), .inc(2'd1), .idx_next(tail_p1));
    fl_idx_inc #(.DEPTH(FL_SIZE), .W(PR_BITS)) u_tail_adv (.idx(tail_q), .inc(pushes), .idx_next(tail_d));

    // Offer: slot 1 looks one entry deeper only when slot 0 is also asking
    always_comb begin
        valid[0] = (count_q != '0);
        valid[1] = fl.dispatch_req[0] ? (count_q >= PR_BITS'(2)) : (count_q != '0);
        prn0     = valid[0] ? entries_q[head_q] : ZERO;
        prn1     = ZERO;
        if (valid[1]) begin
            prn1 = fl.dispatch_req[0] ? entries_q[head_p1] : entries_q[head_q];
        end
        grant = fl.dispatch_req & valid;
        pops  = {1'b0, grant[0]} + {1'b0, grant[1]};
    end

    // Push: capacity is judged against pre-pop occupancy; excess pushes are dropped
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            ret[i].valid = fl.retire_valid[i];
            ret[i].PRN   = fl.retire_PRN[i];
            push_req[i]  = ret[i].valid && (ret[i].PRN != ZERO);
        end
        push0       = push_req[0] && (count_q < PR_BITS'(FL_SIZE));
        room_after0 = {1'b0, count_q} + {{PR_BITS{1'b0}}, push0};
        push1       = push_req[1] && (room_after0 < (PR_BITS+1)'(FL_SIZE));
        pushes      = {1'b0, push0} + {1'b0, push1};
        push_demand = {2'b00, count_q} + {{PR_BITS{1'b0}}, push_req[0]}
                    + {{PR_BITS{1'b0}}, push_req[1]};

        entries_d = entries_q;
        if (push0) begin
            entries_d[tail_q] = ret[0].PRN;
        end
        if (push1) begin
            entries_d[push0 ? tail_p1 : tail_q] = ret[1].PRN;
        end
        count_d = count_q + {{(PR_BITS-2){1'b0}}, pushes} - {{(PR_BITS-2){1'b0}}, pops};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FL_SIZE; i++) begin
                entries_q[i] <= PR_BITS'(i);
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= PR_BITS'(FL_SIZE);
        end else begin
            overflow_chk: assert (push_demand <= (PR_BITS+2)'(FL_SIZE));
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        fl.free_PRN[0] = prn0;
        fl.free_PRN[1] = prn1;
        fl.free_valid  = valid;
        fl.num_free    = count_q;
        fl.stall       = (count_q < PR_BITS'(2));
    end
endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - randomized and directed checks of free_list against a queue model
module tb_free_list;
    import free_list_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    free_list_if fl_if ();
    free_list dut (.clock(clock), .reset(reset), .fl(fl_if));

    int q[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic void model_reset();
        q.delete();
        for (int i = 0; i < FL_SIZE; i++) q.push_back(i);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit rst, input bit [1:0] req, input bit [1:0] rv, input int p0, input int p1);
        reset                  = rst;
        fl_if.dispatch_req     = req;
        fl_if.retire_valid     = rv;
        fl_if.retire_PRN[0]    = PR_BITS'(p0);
        fl_if.retire_PRN[1]    = PR_BITS'(p1);
    endtask

    task automatic check_model();
        int n;
        bit r0;
        int e0, e1;
        bit v0, v1;
        n  = q.size();
        r0 = fl_if.dispatch_req[0];
        e0 = (n >= 1) ? q[0] : ZERO_PRN;
        if (r0) e1 = (n >= 2) ? q[1] : ZERO_PRN;
        else    e1 = (n >= 1) ? q[0] : ZERO_PRN;
        v0 = (n >= 1);
        v1 = r0 ? (n >= 2) : (n >= 1);
        chk("free_prn0", 32'(fl_if.free_PRN[0]), 32'(e0));
        chk("free_prn1", 32'(fl_if.free_PRN[1]), 32'(e1));
        chk("free_valid", 32'(fl_if.free_valid), 32'({v1, v0}));
        chk("num_free", 32'(fl_if.num_free), 32'(n));
        chk("stall", 32'(fl_if.stall), 32'(n < 2));
    endtask

    task automatic update_model(input bit rst, input bit [1:0] req, input bit [1:0] rv, input int p0, input int p1);
        int n, pops;
        if (rst) begin
            model_reset();
            return;
        end
        n    = q.size();
        pops = 0;
        if (req[0] && n >= 1) pops++;
        if (req[1] && (req[0] ? n >= 2 : n >= 1)) pops++;
        repeat (pops) void'(q.pop_front());
        if (rv[0] && p0 != ZERO_PRN) q.push_back(p0);
        if (rv[1] && p1 != ZERO_PRN) q.push_back(p1);
    endtask

    task automatic step(input bit rst, input bit [1:0] req, input bit [1:0] rv, input int p0, input int p1);
        drive(rst, req, rv, p0, p1);
        #1;
        check_model();
        @(posedge clock);
        update_model(rst, req, rv, p0, p1);
        @(negedge clock);
    endtask

    task automatic peek(input bit [1:0] req);
        drive(1'b0, req, 2'b00, 0, 0);
        #1;
    endtask

    task automatic check_reset_literals();
        peek(2'b01);
        chk("rst_prn0", 32'(fl_if.free_PRN[0]), 32'd0);
        chk("rst_prn1", 32'(fl_if.free_PRN[1]), 32'd1);
        chk("rst_valid", 32'(fl_if.free_valid), 32'd3);
        chk("rst_num_free", 32'(fl_if.num_free), 32'd63);
        chk("rst_stall", 32'(fl_if.stall), 32'd0);
    endtask

    initial begin
        drive(1'b1, 2'b00, 2'b00, 0, 0);
        @(posedge clock);
        model_reset();
        @(negedge clock);
        check_reset_literals();

        step(1'b0, 2'b11, 2'b00, 0, 0);
        peek(2'b01);
        chk("pair_prn0", 32'(fl_if.free_PRN[0]), 32'd2);
        chk("pair_prn1", 32'(fl_if.free_PRN[1]), 32'd3);
        chk("pair_num_free", 32'(fl_if.num_free), 32'd61);
        peek(2'b10);
        chk("slot1_only_prn1", 32'(fl_if.free_PRN[1]), 32'd2);
        step(1'b0, 2'b10, 2'b00, 0, 0);
        peek(2'b00);
        chk("single_num_free", 32'(fl_if.num_free), 32'd60);

        repeat (30) step(1'b0, 2'b11, 2'b00, 0, 0);
        peek(2'b11);
        chk("empty_num_free", 32'(fl_if.num_free), 32'd0);
        chk("empty_valid", 32'(fl_if.free_valid), 32'd0);
        chk("empty_stall", 32'(fl_if.stall), 32'd1);
        chk("empty_prn0", 32'(fl_if.free_PRN[0]), 32'd63);
        chk("empty_prn1", 32'(fl_if.free_PRN[1]), 32'd63);
        step(1'b0, 2'b11, 2'b00, 0, 0);
        peek(2'b00);
        chk("empty_req_num_free", 32'(fl_if.num_free), 32'd0);

        step(1'b0, 2'b11, 2'b11, 5, 7);
        peek(2'b01);
        chk("no_bypass_prn0", 32'(fl_if.free_PRN[0]), 32'd5);
        chk("no_bypass_prn1", 32'(fl_if.free_PRN[1]), 32'd7);
        chk("no_bypass_num_free", 32'(fl_if.num_free), 32'd2);
        step(1'b0, 2'b00, 2'b11, 12, 63);
        peek(2'b00);
        chk("zero_prn_drop_num_free", 32'(fl_if.num_free), 32'd3);

        step(1'b1, 2'b00, 2'b00, 0, 0);
        repeat (31) step(1'b0, 2'b11, 2'b00, 0, 0);
        step(1'b0, 2'b00, 2'b01, 40, 0);
        peek(2'b01);
        chk("wrap_prn0", 32'(fl_if.free_PRN[0]), 32'd62);
        chk("wrap_prn1", 32'(fl_if.free_PRN[1]), 32'd40);
        step(1'b0, 2'b11, 2'b00, 0, 0);
        step(1'b0, 2'b00, 2'b11, 20, 21);
        peek(2'b01);
        chk("post_wrap_prn0", 32'(fl_if.free_PRN[0]), 32'd20);
        chk("post_wrap_prn1", 32'(fl_if.free_PRN[1]), 32'd21);
        step(1'b0, 2'b01, 2'b00, 0, 0);
        step(1'b1, 2'b11, 2'b11, 3, 4);
        check_reset_literals();

        for (int c = 0; c < 3000; c++) begin
            bit        rst;
            bit [1:0]  req, rv;
            int        p0, p1, space, want;
            rst   = ($urandom_range(0, 299) == 0);
            req   = 2'($urandom);
            rv    = 2'($urandom);
            p0    = $urandom_range(0, 63);
            p1    = $urandom_range(0, 63);
            space = FL_SIZE - q.size();
            want  = int'(rv[0] && p0 != ZERO_PRN) + int'(rv[1] && p1 != ZERO_PRN);
            if (want > space) begin
                rv[1] = 1'b0;
                want  = int'(rv[0] && p0 != ZERO_PRN);
                if (want > space) rv[0] = 1'b0;
            end
            step(rst, req, rv, p0, p1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Shared physical-register free list directly upstream of the RAT; drives the RAT's two-slot `free_PRN` input every cycle.
- Dispatch consumes 0–2 PRNs per cycle; retirement returns 0–2 PRNs per cycle. Squash recovery also returns PRNs, through the same ports.
- Circular FIFO of PRNs shared by both threads. PRN `PR_SIZE-1` is the zero/invalid PRN and is never stored.

Parameters:
- PR_SIZE, default 64: number of physical registers. Equal to the `PR_SIZE` define.
- PR_BITS, default 6: PRN width, clog2(PR_SIZE). Equal to the `PR_BITS` define.
- FL_SIZE, default PR_SIZE-1: FIFO depth. Not a power of two; all index wrap is explicit.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dispatch_req  in  2  per-slot request for a destination PRN; slot 0 is older
- retire_valid  in  2  per-slot return of a PRN (retired old mapping, or squashed dest)
- retire_PRN  in  2×PR_BITS  PRNs being returned
- free_PRN  out  2×PR_BITS  PRNs offered to RAT slot 0 and slot 1
- free_valid  out  2  free_PRN[i] is backed by a real entry
- num_free  out  PR_BITS  current occupancy count, 0..FL_SIZE
- stall  out  1  asserted when num_free < 2; dispatch must not issue a pair

Behaviour:
- State:
  - `entries[FL_SIZE]`, `head`, `tail`, `count`.
  - `head` is the next PRN to hand out; `tail` is the next slot to write.
  - Full when `count == FL_SIZE`, in which case `head == tail`.
- Reset (synchronous, has priority over everything):
  - `entries[i] = i` for i = 0..FL_SIZE-1; `head = tail = 0`; `count = FL_SIZE`.
  - Outputs after reset: `free_PRN = {1,0}`, `free_valid = 2'b11`, `num_free = 63`, `stall = 0`.
  - A reset mid-operation discards all in-flight state; any same-cycle push or pop is ignored.
- Offer (combinational from state plus `dispatch_req[0]`):
  - `free_PRN[0] = entries[head]`.
  - `free_PRN[1] = dispatch_req[0] ? entries[head+1 wrapped] : entries[head]`.
  - `free_valid[0] = (count >= 1)`.
  - `free_valid[1] = dispatch_req[0] ? (count >= 2) : (count >= 1)`.
  - Unused/invalid outputs are driven to `PR_SIZE-1`.
- Pop:
  - A slot pops only if `dispatch_req[i] && free_valid[i]`.
  - `pops` = number of granted slots (0–2); `head` advances by `pops` with wrap at FL_SIZE.
  - A request without valid is dropped with no side effect.
- Push:
  - A slot pushes only if `retire_valid[i] && retire_PRN[i] != PR_SIZE-1`.
  - Slot 0 is written before slot 1; `tail` advances by `pushes`.
  - If both slots push, slot 0 goes to `tail` and slot 1 to `tail+1`.
- Same-cycle push and pop:
  - `count_next = count + pushes - pops`.
  - No bypass: a PRN pushed in cycle N can first be offered in cycle N+1.
  - Pops are evaluated against pre-push `count`, so at `count == 0` with pushes present, nothing is granted that cycle.
- Latency: one cycle from push to visibility; pops take effect at the next clock edge.
- Overflow: `count + pushes > FL_SIZE` is illegal. The simulation-only assertion fires and the pushes beyond capacity are dropped.
- Index wrap: `(idx + k) >= FL_SIZE ? idx + k - FL_SIZE : idx + k`, with k in {1, 2}.

Decomposition:
- `PR_SIZE`, `PR_BITS`, and a new `ZERO_PRN` (= `PR_SIZE-1`) go in the shared defines header next to `AR_SIZE` and `ZERO_REG`.
- Add a `FL_RETIRE` packed struct (`valid`, `PRN`) to the shared header for the retire/squash interface.
- One natural sub-module: `fl_idx_inc`, the combinational wrap-add for head/tail by 0–2.

Test Plan:
- Reset, then idle → `free_PRN = {1,0}`, `free_valid = 11`, `num_free = 63`, `stall = 0`.
- `dispatch_req = 11` for one cycle → next cycle `free_PRN = {3,2}`, `num_free = 61`; with `req = 10` → `free_PRN[1] = 2`, and next cycle `num_free = 60`.
- Drain with 31 paired pops plus 1 single pop → `num_free = 0`, `free_valid = 00`, `stall = 1`, outputs = 63. Further requests produce no change.
- From empty, `retire_valid = 11`, `retire_PRN = {7,5}` with `req = 11` → nothing granted that cycle. Next cycle `free_PRN = {7,5}`, `num_free = 2`.
- Retire `{63,12}` → only 12 is pushed; `num_free` increments by 1.
- Wrap test: pop until `head = 62`, then pair-pop → `free_PRN` pair before the pop is `{entries[0], 62}` and `head` wraps to 1. Assert reset mid-drain → state returns to the reset values in the first test.
